// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB low/full-speed transmit encoder:
// FSM states, default bit timing and differential line levels.
package usb_tx_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    // Line levels packed as {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [2:0] STUFF_RUN = 3'd6;

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] level);
        return (level == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Clear-able up-counter that counts 1..rollover_val and wraps back to 1;
// rollover_flag is registered and high while count_out equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_next;

    always_comb begin
        count_next = count_out;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_next = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
            end else begin
                count_next = count_out + {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= count_next;
            rollover_flag <= (count_next == rollover_val);
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB packet transmitter: serialises bytes LSB-first with bit stuffing and
// NRZI encoding onto registered D+/D- lines, terminated by SE0,SE0,J EOP.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_data_get,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy
);

    localparam logic [3:0] ROLL_VAL = 4'(CLKS_PER_BIT);

    state_t     state, state_n;
    logic [7:0] shift_reg, shift_n;
    logic       last_byte, last_n;
    logic       data_done, done_n;
    logic [2:0] bit_cnt, bit_n;
    logic [2:0] ones_cnt, ones_n;
    logic [1:0] line, line_n;
    logic       get;

    logic [3:0] clk_cnt;
    logic       period_flag;
    logic       period_end;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       next_bit;

    assign period_end = period_flag && (state != IDLE);

    // Counter sits at 0 in IDLE so the accepting edge moves it to 1, and is
    // forced back to 0 when EOP ends so a same-cycle restart times correctly.
    assign cnt_clear  = ((state == IDLE) && !tx_start) || ((state == EOP_J) && period_end);
    assign cnt_enable = (state != IDLE) || tx_start;

    flex_counter #(
        .NUM_CNT_BITS(4)
    ) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_enable),
        .rollover_val (ROLL_VAL),
        .count_out    (clk_cnt),
        .rollover_flag(period_flag)
    );

    always_comb begin
        state_n  = state;
        shift_n  = shift_reg;
        last_n   = last_byte;
        done_n   = data_done;
        bit_n    = bit_cnt;
        ones_n   = ones_cnt;
        line_n   = line;
        get      = 1'b0;
        next_bit = 1'b0;

        case (state)
            IDLE: begin
                if (tx_start) begin
                    get      = 1'b1;
                    shift_n  = tx_data;
                    last_n   = tx_last;
                    done_n   = 1'b0;
                    bit_n    = 3'd0;
                    next_bit = tx_data[0];
                    ones_n   = next_bit ? 3'd1 : 3'd0;
                    line_n   = next_bit ? LINE_J : nrzi_toggle(LINE_J);
                    state_n  = DATA;
                end
            end

            DATA: begin
                if (period_end) begin
                    // Advance to the next pending bit first; a stuff bit, if
                    // due, goes out before that pending bit.
                    if (bit_cnt == 3'd7) begin
                        if (last_byte) begin
                            done_n = 1'b1;
                        end else begin
                            get     = 1'b1;
                            shift_n = tx_data;
                            last_n  = tx_last;
                            bit_n   = 3'd0;
                        end
                    end else begin
                        shift_n = {1'b0, shift_reg[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                    end

                    next_bit = shift_n[0];
                    if (ones_cnt == STUFF_RUN) begin
                        state_n = STUFF;
                        ones_n  = 3'd0;
                        line_n  = nrzi_toggle(line);
                    end else if ((bit_cnt == 3'd7) && last_byte) begin
                        state_n = EOP_SE0;
                        bit_n   = 3'd0;
                        line_n  = LINE_SE0;
                    end else begin
                        state_n = DATA;
                        ones_n  = next_bit ? (ones_cnt + 3'd1) : 3'd0;
                        line_n  = next_bit ? line : nrzi_toggle(line);
                    end
                end
            end

            STUFF: begin
                if (period_end) begin
                    if (data_done) begin
                        state_n = EOP_SE0;
                        bit_n   = 3'd0;
                        line_n  = LINE_SE0;
                    end else begin
                        next_bit = shift_reg[0];
                        state_n  = DATA;
                        ones_n   = next_bit ? 3'd1 : 3'd0;
                        line_n   = next_bit ? line : nrzi_toggle(line);
                    end
                end
            end

            EOP_SE0: begin
                if (period_end) begin
                    if (bit_cnt == 3'd1) begin
                        state_n = EOP_J;
                        line_n  = LINE_J;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end

            EOP_J: begin
                if (period_end) begin
                    state_n = IDLE;
                    line_n  = LINE_J;
                    shift_n = 8'd0;
                    last_n  = 1'b0;
                    done_n  = 1'b0;
                    bit_n   = 3'd0;
                    ones_n  = 3'd0;
                end
            end

            default: begin
                state_n = IDLE;
                line_n  = LINE_J;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            shift_reg <= 8'd0;
            last_byte <= 1'b0;
            data_done <= 1'b0;
            bit_cnt   <= 3'd0;
            ones_cnt  <= 3'd0;
            line      <= LINE_J;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            last_byte <= last_n;
            data_done <= done_n;
            bit_cnt   <= bit_n;
            ones_cnt  <= ones_n;
            line      <= line_n;
        end
    end

    // Gated by reset so a held tx_start cannot advance upstream during reset.
    assign tx_data_get = get && n_rst;
    assign tx_busy     = (state != IDLE);
    assign dplus_out   = line[1];
    assign dminus_out  = line[0];

endmodule
